// File: rtl/rwback_pipe_reg_if.sv
// Memory->writeback bus: memory-stage values, pipe control, and the registered W-stage copies.
// The perf counter signals exist only when PIPE_WB_PERF_EN is defined.
interface rwback_pipe_reg_if #(
  parameter int DATA_W  = 64,
  parameter int REG_W   = 4,
  parameter int STAT_W  = 2,
  parameter int ICODE_W = 4
`ifdef PIPE_WB_PERF_EN
  , parameter int CNT_W = 32
`endif
);
  logic               W_stall;
  logic               W_bubble;
  logic [STAT_W-1:0]  m_stat;
  logic [ICODE_W-1:0] m_icode;
  logic [DATA_W-1:0]  m_valE;
  logic [DATA_W-1:0]  m_valM;
  logic [DATA_W-1:0]  m_valA;
  logic [REG_W-1:0]   m_dstE;
  logic [REG_W-1:0]   m_dstM;
  logic [STAT_W-1:0]  W_stat;
  logic [ICODE_W-1:0] W_icode;
  logic [DATA_W-1:0]  W_valE;
  logic [DATA_W-1:0]  W_valM;
  logic [DATA_W-1:0]  W_valA;
  logic [REG_W-1:0]   W_dstE;
  logic [REG_W-1:0]   W_dstM;
  logic               W_frozen;
`ifdef PIPE_WB_PERF_EN
  logic [CNT_W-1:0]   W_stall_cnt;
  logic [CNT_W-1:0]   W_bubble_cnt;
`endif

  modport master (
`ifdef PIPE_WB_PERF_EN
    input  W_stall_cnt, W_bubble_cnt,
`endif
    output W_stall, W_bubble, m_stat, m_icode, m_valE, m_valM, m_valA, m_dstE, m_dstM,
    input  W_stat, W_icode, W_valE, W_valM, W_valA, W_dstE, W_dstM, W_frozen
  );

  modport slave (
`ifdef PIPE_WB_PERF_EN
    output W_stall_cnt, W_bubble_cnt,
`endif
    input  W_stall, W_bubble, m_stat, m_icode, m_valE, m_valM, m_valA, m_dstE, m_dstM,
    output W_stat, W_icode, W_valE, W_valM, W_valA, W_dstE, W_dstM, W_frozen
  );
endinterface

// File: rtl/rwback_pipe_reg.sv
// Memory->writeback pipeline register with stall, bubble and a sticky exception freeze.
// Define PIPE_WB_PERF_EN to add saturating stall/bubble perf counters.
module rwback_pipe_reg #(
  parameter int DATA_W  = 64,
  parameter int REG_W   = 4,
  parameter int STAT_W  = 2,
  parameter int ICODE_W = 4
`ifdef PIPE_WB_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  rwback_pipe_reg_if.slave   wb
);
  localparam logic [STAT_W-1:0]  STAT_AOK  = '0;
  localparam logic [ICODE_W-1:0] ICODE_NOP = ICODE_W'(1);
  localparam logic [REG_W-1:0]   RNONE     = '1;

  logic               frozen_p1;
  logic [STAT_W-1:0]  stat_p1;
  logic [ICODE_W-1:0] icode_p1;
  logic [DATA_W-1:0]  valE_p1;
  logic [DATA_W-1:0]  valM_p1;
  logic [DATA_W-1:0]  valA_p1;
  logic [REG_W-1:0]   dstE_p1;
  logic [REG_W-1:0]   dstM_p1;

  logic do_bubble;
  logic do_stall;
  logic do_load;

  // Priority: freeze > bubble > stall > load; exactly one of these (or none when frozen).
  assign do_bubble = !frozen_p1 && wb.W_bubble;
  assign do_stall  = !frozen_p1 && !wb.W_bubble && wb.W_stall;
  assign do_load   = !frozen_p1 && !wb.W_bubble && !wb.W_stall;

  // ---- M -> W stage boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frozen_p1 <= 1'b0;
      stat_p1   <= STAT_AOK;
      icode_p1  <= ICODE_NOP;
      valE_p1   <= '0;
      valM_p1   <= '0;
      valA_p1   <= '0;
      dstE_p1   <= RNONE;
      dstM_p1   <= RNONE;
    end else if (do_bubble) begin
      stat_p1   <= STAT_AOK;
      icode_p1  <= ICODE_NOP;
      valE_p1   <= '0;
      valM_p1   <= '0;
      valA_p1   <= '0;
      dstE_p1   <= RNONE;
      dstM_p1   <= RNONE;
    end else if (do_load) begin
      // The faulting instruction itself is captured, then everything locks until reset.
      frozen_p1 <= (wb.m_stat != STAT_AOK);
      stat_p1   <= wb.m_stat;
      icode_p1  <= wb.m_icode;
      valE_p1   <= wb.m_valE;
      valM_p1   <= wb.m_valM;
      valA_p1   <= wb.m_valA;
      dstE_p1   <= wb.m_dstE;
      dstM_p1   <= wb.m_dstM;
    end
  end

  assign wb.W_frozen = frozen_p1;
  assign wb.W_stat   = stat_p1;
  assign wb.W_icode  = icode_p1;
  assign wb.W_valE   = valE_p1;
  assign wb.W_valM   = valM_p1;
  assign wb.W_valA   = valA_p1;
  assign wb.W_dstE   = dstE_p1;
  assign wb.W_dstM   = dstM_p1;

`ifdef PIPE_WB_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] stall_cnt_p1;
  logic [CNT_W-1:0] bubble_cnt_p1;

  // ---- perf counters, updated alongside the W stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_p1  <= '0;
      bubble_cnt_p1 <= '0;
    end else begin
      if (do_stall)  stall_cnt_p1  <= sat_inc(stall_cnt_p1);
      if (do_bubble) bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
    end
  end

  assign wb.W_stall_cnt  = stall_cnt_p1;
  assign wb.W_bubble_cnt = bubble_cnt_p1;
`endif
endmodule
